wb_router: RTL and testbench

Write-back router for the 8-bit datapath. Takes the ALU result and steers it into Register A, Register B and/or data memory in one command, using a 3-bit destination mask. Register A and Register B live inside this block and are exported to the operand multiplexers. Data-memory writes use a valid/ack handshake with a bounded wait and a sticky timeout error.

---
 rtl/wb_router_if.sv | 25 ++
 rtl/wb_router.sv | 102 ++++++++++
 tb/tb_wb_router.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_router_if.sv
// Command and data-memory bus for wb_router.
// Signal names keep the original port names so existing wiring maps one-to-one.
interface wb_router_if;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [2:0] dst_i;
    logic [7:0] data_i;
    logic [7:0] addr_i;
    logic       mem_we_o;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic       mem_ack_i;

    // Router side: consumes commands, drives the memory write request.
    modport slave (
        input  wr_valid_i, dst_i, data_i, addr_i, mem_ack_i,
        output wr_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Producer/memory side, as seen from outside the router.
    modport master (
        output wr_valid_i, dst_i, data_i, addr_i, mem_ack_i,
        input  wr_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/wb_router.sv
// Write-back router: steers the ALU result into RegA, RegB and/or data memory.
// Memory writes wait for ack with a bounded timeout and a sticky error flag.
module wb_router #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_router_if.slave  bus,
    output logic [7:0]  rega_o,
    output logic [7:0]  regb_o,
    output logic        err_o,
    input  logic        err_clr_i
);
    typedef enum logic {IDLE, MEM_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] rega, rega_nxt;
    logic [7:0] regb, regb_nxt;
    logic [7:0] addr_q, addr_nxt;
    logic [7:0] wdata_q, wdata_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       we_q, we_nxt;
    logic       err_q, err_nxt;
    logic       timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rega    <= '0;
            regb    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rega    <= rega_nxt;
            regb    <= regb_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            cnt     <= cnt_nxt;
            we_q    <= we_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rega_nxt  = rega;
        regb_nxt  = regb;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        timeout   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.wr_valid_i) begin
                    if (bus.dst_i[0]) rega_nxt = bus.data_i;
                    if (bus.dst_i[1]) regb_nxt = bus.data_i;
                    if (bus.dst_i[2]) begin
                        addr_nxt  = bus.addr_i;
                        wdata_nxt = bus.data_i;
                        we_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // Ack takes priority, so an ack on the last allowed cycle still completes.
                if (bus.mem_ack_i) begin
                    we_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    we_nxt    = 1'b0;
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase

        // A timeout in the same cycle as a clear leaves the flag set.
        if (timeout)        err_nxt = 1'b1;
        else if (err_clr_i) err_nxt = 1'b0;
        else                err_nxt = err_q;
    end

    assign bus.wr_ready_o  = (state == IDLE);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign rega_o          = rega;
    assign regb_o          = regb;
    assign err_o           = err_q;
endmodule

// File: tb/tb_wb_router.sv
// Bench for wb_router: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural reference model.
module tb_wb_router;
    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] rega, regb;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: a pending write remembers how many cycles it has been offered.
    logic [7:0] m_rega, m_regb, m_addr, m_wdata;
    logic       m_busy, m_err;
    int         m_offered;
    logic       last_acc;

    wb_router_if bus ();

    wb_router #(.MEM_TIMEOUT(T)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .rega_o    (rega),
        .regb_o    (regb),
        .err_o     (err),
        .err_clr_i (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic tmo;
        tmo = 1'b0;
        last_acc = 1'b0;
        if (rst) begin
            m_rega = '0; m_regb = '0; m_addr = '0; m_wdata = '0;
            m_busy = 1'b0; m_err = 1'b0; m_offered = 0;
        end else begin
            if (!m_busy) begin
                if (bus.wr_valid_i) begin
                    last_acc = 1'b1;
                    if (bus.dst_i[0]) m_rega = bus.data_i;
                    if (bus.dst_i[1]) m_regb = bus.data_i;
                    if (bus.dst_i[2]) begin
                        m_busy = 1'b1; m_offered = 1;
                        m_addr = bus.addr_i; m_wdata = bus.data_i;
                    end
                end
            end else if (bus.mem_ack_i) begin
                m_busy = 1'b0;
            end else if (m_offered == int'(T)) begin
                m_busy = 1'b0; tmo = 1'b1;
            end else begin
                m_offered++;
            end
            if (tmo) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rega", rega, m_rega);
        chk("regb", regb, m_regb);
        chk("ready", bus.wr_ready_o, !m_busy);
        chk("mem_we", bus.mem_we_o, m_busy);
        chk("mem_addr", bus.mem_addr_o, m_addr);
        chk("mem_wdata", bus.mem_wdata_o, m_wdata);
        chk("err", err, m_err);
    endtask

    initial begin
        bus.wr_valid_i = 1'b0; bus.dst_i = '0; bus.data_i = '0;
        bus.addr_i = '0; bus.mem_ack_i = 1'b0;

        // Reset values
        rst = 1'b1; step(); step();
        chk("rst_rega", rega, 8'h00);
        chk("rst_regb", regb, 8'h00);
        chk("rst_we", bus.mem_we_o, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", bus.wr_ready_o, 1'b1);
        rst = 1'b0;

        // Back-to-back register writes
        bus.wr_valid_i = 1'b1; bus.dst_i = 3'b001; bus.data_i = 8'h5A; step();
        chk("b2b_rega", rega, 8'h5A);
        bus.dst_i = 3'b010; bus.data_i = 8'hC3; step();
        chk("b2b_regb", regb, 8'hC3);
        chk("b2b_we", bus.mem_we_o, 1'b0);
        bus.wr_valid_i = 1'b0;

        // Triple write with ack in the 4th high cycle, second command stalled meanwhile
        bus.wr_valid_i = 1'b1; bus.dst_i = 3'b111; bus.data_i = 8'h7E; bus.addr_i = 8'h20; step();
        chk("tri_rega", rega, 8'h7E);
        chk("tri_regb", regb, 8'h7E);
        chk("tri_addr", bus.mem_addr_o, 8'h20);
        chk("tri_wdata", bus.mem_wdata_o, 8'h7E);
        bus.dst_i = 3'b001; bus.data_i = 8'h11; bus.addr_i = 8'hEE;
        step(); step(); step();
        chk("tri_we_held", bus.mem_we_o, 1'b1);
        chk("stall_rega", rega, 8'h7E);
        bus.mem_ack_i = 1'b1; step(); bus.mem_ack_i = 1'b0;
        chk("tri_we_done", bus.mem_we_o, 1'b0);
        chk("tri_ready", bus.wr_ready_o, 1'b1);
        chk("stall_rega2", rega, 8'h7E);
        step();
        chk("stall_acc", rega, 8'h11);
        bus.wr_valid_i = 1'b0;

        // Timeout, ack never arrives
        bus.wr_valid_i = 1'b1; bus.dst_i = 3'b100; bus.data_i = 8'h99; bus.addr_i = 8'h44; step();
        bus.wr_valid_i = 1'b0;
        for (int i = 0; i < int'(T) - 1; i++) begin
            chk("to_we_high", bus.mem_we_o, 1'b1);
            step();
        end
        chk("to_we_last", bus.mem_we_o, 1'b1);
        step();
        chk("to_we_low", bus.mem_we_o, 1'b0);
        chk("to_err", err, 1'b1);
        chk("to_ready", bus.wr_ready_o, 1'b1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("to_clr", err, 1'b0);

        // Repeat timeout with clear on the abort edge
        bus.wr_valid_i = 1'b1; bus.dst_i = 3'b100; step();
        bus.wr_valid_i = 1'b0;
        for (int i = 0; i < int'(T) - 1; i++) step();
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("to_clr_race", err, 1'b1);

        // Reset while a write is pending
        bus.wr_valid_i = 1'b1; bus.dst_i = 3'b001; bus.data_i = 8'h33; step();
        bus.dst_i = 3'b100; bus.data_i = 8'h05; bus.addr_i = 8'h06; step();
        bus.wr_valid_i = 1'b0; step();
        chk("mid_rega", rega, 8'h33);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rega_rst", rega, 8'h00);
        chk("mid_we_rst", bus.mem_we_o, 1'b0);
        chk("mid_addr_rst", bus.mem_addr_o, 8'h00);
        chk("mid_err_rst", err, 1'b0);
        bus.mem_ack_i = 1'b1; step(); bus.mem_ack_i = 1'b0;
        chk("late_ack_we", bus.mem_we_o, 1'b0);
        chk("late_ack_ready", bus.wr_ready_o, 1'b1);

        // Random traffic; producer holds a command until it is accepted
        for (int i = 0; i < 800; i++) begin
            if (!bus.wr_valid_i) begin
                bus.wr_valid_i = ($urandom_range(0, 3) != 0);
                bus.dst_i  = 3'($urandom);
                bus.data_i = 8'($urandom);
                bus.addr_i = 8'($urandom);
            end
            bus.mem_ack_i = ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
            if (last_acc) bus.wr_valid_i = 1'b0;
        end
        rst = 1'b0; err_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
